// File: rtl/entry_sequencer.sv
// Operand/opcode entry sequencer: synchronizes and debounces the advance
// button, steps through operand A, operand B and opcode slots, and issues
// one-cycle write strobes toward the operand store.
module entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_OPS         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_clear,
  input  logic [3:0] data_in,
  output logic [1:0] address,
  output logic [3:0] write,
  output logic       enable,
  output logic       full,
  output logic       err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    SLOT_A  = 2'b00,
    SLOT_B  = 2'b01,
    SLOT_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  logic             next_p0, next_p1;
  logic             clr_p0, clr_p1;
  logic [CNT_W-1:0] db_cnt;
  logic             db_level, db_level_d;
  logic             press;
  logic             op_ok;
  state_t           state, state_nx;
  logic             enable_nx, err_nx;
  logic [3:0]       write_nx;

  // Two-flop synchronizers for both raw buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      next_p0 <= 1'b0;
      next_p1 <= 1'b0;
      clr_p0  <= 1'b0;
      clr_p1  <= 1'b0;
    end else begin
      next_p0 <= btn_next;
      next_p1 <= next_p0;
      clr_p0  <= btn_clear;
      clr_p1  <= clr_p0;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (next_p1 != db_level) begin
      if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered one-cycle press pulse on the debounced rising edge only
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level_d <= 1'b0;
      press      <= 1'b0;
    end else begin
      db_level_d <= db_level;
      press      <= db_level & ~db_level_d;
    end
  end

  assign op_ok = ({1'b0, data_in} < 5'(NUM_OPS));

  // State and output registers; the state encoding doubles as the slot address
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SLOT_A;
      enable <= 1'b0;
      err    <= 1'b0;
      write  <= 4'b0000;
    end else begin
      state  <= state_nx;
      enable <= enable_nx;
      err    <= err_nx;
      write  <= write_nx;
    end
  end

  // Next state: clear wins, then the slot advances at the end of its strobe
  always_comb begin
    state_nx = state;
    if (clr_p1) begin
      state_nx = SLOT_A;
    end else if (enable) begin
      case (state)
        SLOT_A:  state_nx = SLOT_B;
        SLOT_B:  state_nx = SLOT_OP;
        SLOT_OP: state_nx = SHOW;
        default: state_nx = state;
      endcase
    end else if (press && state == SHOW) begin
      state_nx = SLOT_A;
    end
  end

  // Next outputs: a press schedules a strobe, or an error for a bad opcode
  always_comb begin
    enable_nx = 1'b0;
    err_nx    = 1'b0;
    write_nx  = write;
    if (!clr_p1 && press && !enable) begin
      case (state)
        SLOT_A, SLOT_B: begin
          enable_nx = 1'b1;
          write_nx  = data_in;
        end
        SLOT_OP: begin
          if (op_ok) begin
            enable_nx = 1'b1;
            write_nx  = data_in;
          end else begin
            err_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign address = state;
  assign full    = (state == SHOW);

endmodule

// File: doc/entry_sequencer.md
ENTRY_SEQUENCER -- requirements
Module: entry_sequencer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to change debounced button level; SHALL be >= 2.
REQ-002 Parameter: NUM_OPS, 8, opcode values 0..NUM_OPS-1 are valid in the opcode slot; range 1..16.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_next  input  1  raw, asynchronous, bouncing "enter/advance" pushbutton.
REQ-006 btn_clear  input  1  raw, asynchronous "abort entry" button, level sensitive.
REQ-007 data_in  input  4  nibble from switches, sampled on a confirmed press.
REQ-008 address  output  2  slot select toward the operand store: 00 operand A, 01 operand B, 10 opcode, 11 result/show (no write).
REQ-009 write  output  4  data toward the operand store, valid while enable=1.
REQ-010 enable  output  1  one-cycle write strobe toward the operand store.
REQ-011 full  output  1  high while in SHOW (all three slots entered).
REQ-012 err  output  1  one-cycle pulse on rejected opcode entry.

Function
REQ-013 btn_next and btn_clear SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: counter increments each cycle synchronized btn_next differs from debounced level, clears when equal; on reaching DEBOUNCE_CYCLES debounced level toggles and counter clears.
REQ-015 Press pulse SHALL be a registered one-cycle pulse on debounced level 0->1; release generates nothing.
REQ-016 FSM states SLOT_A, SLOT_B, SLOT_OP, SHOW; address SHALL equal 00, 01, 10, 11 respectively, registered.
REQ-017 Press in SLOT_A/SLOT_B: next cycle enable=1, write=data_in sampled on the press cycle, address=current slot; state advances at end of that enable cycle.
REQ-018 Press in SLOT_OP with data_in < NUM_OPS: same as REQ-017, next state SHOW.
REQ-019 Press in SLOT_OP with data_in >= NUM_OPS: err=1 next cycle, enable stays 0, state stays SLOT_OP.
REQ-020 Press in SHOW: state wraps to SLOT_A next cycle, enable stays 0, write unchanged.
REQ-021 enable SHALL never be high two consecutive cycles; address SHALL never change while enable=1.
REQ-022 write SHALL hold its last value when enable=0.
REQ-023 Any 4-bit value, including 4'b1111, SHALL be accepted in SLOT_A and SLOT_B.
REQ-024 Synchronized btn_clear high: state SHALL go to SLOT_A next cycle, enable 0, any press or pending enable that cycle discarded; remains SLOT_A while held.
REQ-025 Priority: reset > btn_clear > press.
REQ-026 Latency: raw btn_next rise (clean) to enable=1 SHALL be exactly DEBOUNCE_CYCLES+4 rising edges.

Reset
REQ-027 reset high at a clock edge SHALL set: state SLOT_A, address 00, write 0000, enable 0, full 0, err 0, synchronizer flops 0, debounced level 0, debounce counter 0, press pulse 0.
REQ-028 Reset mid-operation SHALL abort any pending enable; no write strobe SHALL appear in the cycle after reset deasserts.

Verification
REQ-029 Reset, then clean presses with data_in 3, 5, 2 (DEBOUNCE_CYCLES=4) -> enable pulses with (address,write) = (00,3),(01,5),(10,2), each 8 edges after raw rise; full=1 after third.
REQ-030 Bounce: btn_next toggles high 3 cycles, low 1, repeatedly for 20 cycles, then low (DEBOUNCE_CYCLES=4) -> no enable, address stays 00.
REQ-031 In SLOT_OP, press with data_in=9 (NUM_OPS=8) -> err one cycle, no enable, address stays 10; then press with data_in=7 -> enable with (10,7), full=1.
REQ-032 From SHOW, press -> address 00, full=0, no enable; next press data_in=F -> enable with (00,F).
REQ-033 In SLOT_B, btn_clear held 5 cycles overlapping a press -> address 00, no enable for that press; reset asserted during an enable-pending cycle -> all outputs at REQ-027 values.
